// File: rtl/board_io_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// board_io_pkg : shared constants and helpers for the board I/O conditioner
// Revision 1.0
// ============================================================================
package board_io_pkg;

  localparam logic [1:0] LED_MODE_CORE = 2'd0;
  localparam logic [1:0] LED_MODE_ACT  = 2'd1;
  localparam logic [1:0] LED_MODE_OFF  = 2'd2;
  localparam logic [1:0] LED_MODE_LAMP = 2'd3;

  localparam logic UART_IDLE = 1'b1;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int ctr_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : board_io_pkg
`default_nettype wire

// File: rtl/io_lane_cond.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// io_lane_cond : one UART lane - RX sync + glitch filter, TX register, activity stretcher
// Revision 1.0
// ============================================================================
module io_lane_cond
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 3,
  parameter int STRETCH_CYCLES = 1200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_pad_i,
  input  logic tx_core_i,
  output logic rx_core_o,
  output logic tx_pad_o,
  output logic act_o
);

  localparam int FW = ctr_w(FILT_LEN - 1);
  localparam int SW = ctr_w(STRETCH_CYCLES);
  localparam logic [FW-1:0] FILT_MAX     = FW'(FILT_LEN - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   rx_q, rx_d;
  logic                   tx_q;
  logic [FW-1:0]          filt_q, filt_d;
  logic [SW-1:0]          str_q, str_d;
  logic                   act_evt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    rx_d   = rx_q;
    filt_d = '0;
    if (sync_out != rx_q) begin
      if (filt_q == FILT_MAX) begin
        rx_d = sync_out;
      end else begin
        filt_d = filt_q + 1'b1;
      end
    end

    // RX and TX edges landing together still produce one reload.
    act_evt = (rx_d != rx_q) || (tx_core_i != tx_q);
    if (act_evt) begin
      str_d = STRETCH_LOAD;
    end else if (str_q != '0) begin
      str_d = str_q - 1'b1;
    end else begin
      str_d = str_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{UART_IDLE}};
      rx_q   <= UART_IDLE;
      tx_q   <= UART_IDLE;
      filt_q <= '0;
      str_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pad_i};
      rx_q   <= rx_d;
      tx_q   <= tx_core_i;
      filt_q <= filt_d;
      str_q  <= str_d;
    end
  end

  assign rx_core_o = rx_q;
  assign tx_pad_o  = tx_q;
  assign act_o     = (str_q != '0);

endmodule : io_lane_cond
`default_nettype wire

// File: rtl/board_io_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// board_io_conditioner : pad-side UART/LED conditioning, heartbeat and core reset sync
// Revision 1.0
// ============================================================================
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int NUM_UART       = 1,
  parameter int LED_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_LEN       = 3,
  parameter int STRETCH_CYCLES = 1200000,
  parameter int HB_PERIOD      = 6000000
) (
  input  logic                clkin,
  input  logic                RST_N,
  input  logic [NUM_UART-1:0] uart_rx_pad,
  output logic [NUM_UART-1:0] uart_tx_pad,
  output logic [NUM_UART-1:0] core_rx,
  input  logic [NUM_UART-1:0] core_tx,
  input  logic [LED_W-1:0]    core_leds,
  input  logic [1:0]          led_mode,
  output logic [LED_W-1:0]    leds,
  output logic                core_rst_n,
  output logic                heartbeat
);

  localparam int HW = ctr_w(HB_PERIOD - 1);
  localparam logic [HW-1:0] HB_MAX = HW'(HB_PERIOD - 1);

  if (NUM_UART < 1 || NUM_UART > 8) begin : g_bad_num_uart
    $error("NUM_UART must be in 1..8");
  end
  if (LED_W < NUM_UART + 1) begin : g_bad_led_w
    $error("LED_W must be at least NUM_UART+1");
  end
  if (SYNC_STAGES < 2 || FILT_LEN < 1 || HB_PERIOD < 1) begin : g_bad_timing
    $error("SYNC_STAGES >= 2, FILT_LEN >= 1 and HB_PERIOD >= 1 required");
  end

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [HW-1:0]          hb_cnt_q, hb_cnt_d;
  logic                   hb_q, hb_d;
  logic [LED_W-1:0]       leds_q, leds_d;
  logic [NUM_UART-1:0]    act;

  for (genvar i = 0; i < NUM_UART; i++) begin : g_lane
    io_lane_cond #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILT_LEN      (FILT_LEN),
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_lane (
      .clk_i    (clkin),
      .rst_ni   (RST_N),
      .rx_pad_i (uart_rx_pad[i]),
      .tx_core_i(core_tx[i]),
      .rx_core_o(core_rx[i]),
      .tx_pad_o (uart_tx_pad[i]),
      .act_o    (act[i])
    );
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + 1'b1;
    hb_d     = hb_q;
    if (hb_cnt_q == HB_MAX) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_comb begin
    leds_d = '0;
    case (led_mode)
      LED_MODE_CORE: leds_d = core_leds;
      LED_MODE_ACT: begin
        leds_d[NUM_UART-1:0] = act;
        leds_d[LED_W-1]      = hb_q;
      end
      LED_MODE_OFF:  leds_d = '0;
      default:       leds_d = '1;
    endcase
  end

  // Reset synchroniser: asserts with RST_N, releases after SYNC_STAGES edges.
  always_ff @(posedge clkin or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync_q <= '0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      leds_q     <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      leds_q     <= leds_d;
    end
  end

  assign core_rst_n = rst_sync_q[SYNC_STAGES-1];
  assign heartbeat  = hb_q;
  assign leds       = leds_q;

endmodule : board_io_conditioner
`default_nettype wire
